// File: rtl/timer_bank_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_bank_if : device-bus port bundle for timer_bank
// Rev 1.0
// ---------------------------------------------------------------------------
interface timer_bank_if;
  logic [31:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        addr_err;

  modport master (output addr, re, we, wdata, input rdata, hit, addr_err);
  modport slave  (input addr, re, we, wdata, output rdata, hit, addr_err);
endinterface
`default_nettype wire

// File: rtl/timer_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_bank : NUM_CH prescaled down-counting timers with sticky IRQs
// Rev 1.0
// ---------------------------------------------------------------------------
module timer_bank #(
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00,
  parameter int          CH_STRIDE = 16,
  parameter int          COUNT_W   = 32
) (
  input  wire logic        clk,
  input  wire logic        reset,
  timer_bank_if.slave      bus,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  localparam int          c_SHIFT   = $clog2(CH_STRIDE);
  localparam int          c_CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] c_SPAN    = 32'(NUM_CH * CH_STRIDE);
  localparam logic [31:0] c_HI_MASK = 32'(CH_STRIDE - 1) & ~32'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  logic [31:0]       w_off;
  logic              w_hit;
  logic              w_in_regs;
  logic [c_CH_W-1:0] w_ch;
  logic [1:0]        w_reg;
  logic              w_we_any;
  logic              w_we_full;
  logic              w_err;
  logic              w_wr;
  logic [31:0]       w_rd_word [NUM_CH];

  assign w_off     = bus.addr - BASE_ADDR;
  assign w_hit     = (bus.addr >= BASE_ADDR) && (w_off < c_SPAN);
  assign w_in_regs = ((w_off & c_HI_MASK) == 32'd0);
  assign w_ch      = w_off[c_SHIFT +: c_CH_W];
  assign w_reg     = bus.addr[3:2];
  assign w_we_any  = |bus.we;
  assign w_we_full = &bus.we;

  // Misaligned, partial-word and COUNT writes are all reported as bus errors.
  assign w_err = w_hit && (bus.re || w_we_any) &&
                 ((bus.addr[1:0] != 2'b00) || (w_we_any && !w_we_full) ||
                  (w_we_full && (w_reg == 2'd2)));
  assign w_wr  = w_hit && w_we_full && !w_err && w_in_regs;

  assign bus.hit      = w_hit;
  assign bus.addr_err = w_err;
  assign bus.rdata    = (w_hit && bus.re && !w_err && w_in_regs) ? w_rd_word[w_ch] : 32'd0;
  assign irq_any      = |irq;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [c_CH_W-1:0] c_IDX = c_CH_W'(i);

    logic               r_en;
    logic [1:0]         r_mode;
    logic               r_im;
    logic               r_pend;
    logic [COUNT_W-1:0] r_preset;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_div;
    logic [COUNT_W-1:0] r_presc;
    state_t             r_state;

    logic w_sel;
    logic w_ctrl_wr;
    logic w_tick;

    assign w_sel     = w_wr && (w_ch == c_IDX);
    assign w_ctrl_wr = w_sel && (w_reg == 2'd0);
    assign w_tick    = (r_presc == r_div);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_en     <= 1'b0;
        r_mode   <= 2'b00;
        r_im     <= 1'b0;
        r_pend   <= 1'b0;
        r_preset <= '0;
        r_count  <= '0;
        r_div    <= '0;
        r_presc  <= '0;
        r_state  <= S_IDLE;
      end else begin
        if (w_sel && (w_reg == 2'd1)) r_preset <= bus.wdata[COUNT_W-1:0];
        if (w_sel && (w_reg == 2'd3)) r_div    <= bus.wdata[COUNT_W-1:0];
        // A CTRL write overrides the FSM, so its pending clear beats any set.
        if (w_ctrl_wr) begin
          r_en    <= bus.wdata[0];
          r_mode  <= bus.wdata[2:1];
          r_im    <= bus.wdata[3];
          r_pend  <= 1'b0;
          r_state <= bus.wdata[0] ? S_LOAD : S_IDLE;
        end else begin
          case (r_state)
            S_IDLE: if (r_en) r_state <= S_LOAD;
            S_LOAD: begin
              r_count <= r_preset;
              r_presc <= '0;
              r_state <= S_CNT;
            end
            S_CNT: begin
              if (!r_en) begin
                r_state <= S_IDLE;
              end else if (w_tick) begin
                r_presc <= '0;
                if (r_count > COUNT_W'(1)) begin
                  r_count <= r_count - COUNT_W'(1);
                end else begin
                  r_count <= '0;
                  r_state <= S_INT;
                  if (r_mode != 2'b01) r_pend <= 1'b1;
                end
              end else begin
                r_presc <= r_presc + COUNT_W'(1);
              end
            end
            S_INT: begin
              if (r_mode == 2'b01) begin
                r_state <= S_LOAD;
              end else begin
                r_en    <= 1'b0;
                r_state <= S_IDLE;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end

    assign irq[i] = r_im && (r_pend || ((r_state == S_INT) && (r_mode == 2'b01)));

    assign w_rd_word[i] = (w_reg == 2'd0) ? {28'd0, r_im, r_mode, r_en} :
                          (w_reg == 2'd1) ? 32'(r_preset) :
                          (w_reg == 2'd2) ? 32'(r_count)  :
                                            32'(r_div);
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_timer_bank : directed self-checking bench for timer_bank (4 channels)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_timer_bank;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] irq;
  logic       irq_any;
  int         n_vec = 0;
  int         n_err = 0;
  logic [31:0] d;
  logic [31:0] cnt_ch1 [4] = '{32'd3, 32'd2, 32'd1, 32'd0};
  logic [31:0] cnt_ch2 [5] = '{32'd2, 32'd2, 32'd1, 32'd1, 32'd0};

  timer_bank_if bus();

  timer_bank #(
    .NUM_CH   (4),
    .BASE_ADDR(32'h0000_7f00),
    .CH_STRIDE(16),
    .COUNT_W  (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .irq    (irq),
    .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full-word write: drive at a falling edge, commit on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    bus.addr = a; bus.wdata = v; bus.we = 4'hF; bus.re = 1'b0;
    @(negedge clk);
    bus.we = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.addr = a; bus.re = 1'b1; bus.we = 4'h0;
    #1;
    v = bus.rdata;
    bus.re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addr = '0; bus.re = 1'b0; bus.we = 4'h0; bus.wdata = '0;
    step(2);
    chk("reset_irq", 32'(irq), 32'd0);
    reset = 1'b1;
    step(1);

    // Reset mid-count: ch0 PRESET=10, count down to 5, then pull reset.
    wr(32'h7f04, 32'd10);
    wr(32'h7f0c, 32'd0);
    wr(32'h7f00, 32'h1);
    step(6);
    rd(32'h7f08, d); chk("ch0_count_mid", d, 32'd5);
    reset = 1'b0;
    #1;
    chk("rst_async_irq", 32'(irq), 32'd0);
    chk("rst_async_irq_any", 32'(irq_any), 32'd0);
    step(1);
    reset = 1'b1;
    step(1);
    rd(32'h7f08, d); chk("rst_count", d, 32'd0);
    rd(32'h7f00, d); chk("rst_ctrl", d, 32'd0);
    rd(32'h7f04, d); chk("rst_preset", d, 32'd0);

    // ch1 auto-reload, PRESET=3, DIV=0: period 5, one-cycle irq pulse.
    wr(32'h7f14, 32'd3);
    wr(32'h7f1c, 32'd0);
    wr(32'h7f10, 32'hB);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk($sformatf("ch1_irq_k%0d", k), 32'(irq), (k % 5 == 4) ? 32'h2 : 32'h0);
      chk($sformatf("ch1_any_k%0d", k), 32'(irq_any), (k % 5 == 4) ? 32'h1 : 32'h0);
      if (k <= 4) begin
        rd(32'h7f18, d); chk($sformatf("ch1_count_k%0d", k), d, cnt_ch1[k-1]);
      end
    end
    wr(32'h7f10, 32'h0);
    chk("ch1_off_irq", 32'(irq), 32'd0);

    // ch2 one-shot, PRESET=2, DIV=1: sticky irq, EN self-clears.
    wr(32'h7f2c, 32'd1);
    wr(32'h7f24, 32'd2);
    wr(32'h7f20, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk($sformatf("ch2_irq_k%0d", k), 32'(irq), (k >= 5) ? 32'h4 : 32'h0);
      if (k <= 5) begin
        rd(32'h7f28, d); chk($sformatf("ch2_count_k%0d", k), d, cnt_ch2[k-1]);
      end
    end
    rd(32'h7f20, d); chk("ch2_ctrl_en_clr", d, 32'h8);
    wr(32'h7f20, 32'h0);
    chk("ch2_irq_cleared", 32'(irq), 32'd0);

    // Bus error cases on ch0.
    wr(32'h7f04, 32'h1234);
    bus.addr = 32'h7f02; bus.re = 1'b1; bus.we = 4'h0;
    #1;
    chk("lw_misalign_err", 32'(bus.addr_err), 32'd1);
    chk("lw_misalign_rdata", bus.rdata, 32'd0);
    chk("lw_misalign_hit", 32'(bus.hit), 32'd1);
    step(1);
    bus.addr = 32'h7f04; bus.re = 1'b0; bus.we = 4'h1; bus.wdata = 32'hFF;
    #1;
    chk("sb_err", 32'(bus.addr_err), 32'd1);
    step(1);
    bus.we = 4'h0;
    rd(32'h7f04, d); chk("sb_preset_kept", d, 32'h1234);
    bus.addr = 32'h7f08; bus.we = 4'hF; bus.wdata = 32'h55;
    #1;
    chk("sw_count_err", 32'(bus.addr_err), 32'd1);
    step(1);
    bus.we = 4'h0;
    rd(32'h7f08, d); chk("count_unwritten", d, 32'd0);
    bus.addr = 32'h7f40; bus.re = 1'b1;
    #1;
    chk("oob_hit", 32'(bus.hit), 32'd0);
    chk("oob_err", 32'(bus.addr_err), 32'd0);
    chk("oob_rdata", bus.rdata, 32'd0);
    bus.addr = 32'h7f3c;
    #1;
    chk("last_word_hit", 32'(bus.hit), 32'd1);
    bus.re = 1'b0;
    step(1);

    // ch3 one-shot with IM=0; pending must be cleared by the CTRL write.
    wr(32'h7f34, 32'd1);
    wr(32'h7f3c, 32'd0);
    wr(32'h7f30, 32'h1);
    step(3);
    chk("ch3_masked_irq", 32'(irq), 32'd0);
    rd(32'h7f30, d); chk("ch3_ctrl", d, 32'd0);
    wr(32'h7f30, 32'h8);
    chk("ch3_unmask_irq", 32'(irq), 32'd0);
    step(1);
    chk("ch3_unmask_irq_later", 32'(irq), 32'd0);

    // ch0 (PRESET=3) and ch1 (PRESET=2, enabled one cycle later) hit INT together.
    wr(32'h7f04, 32'd3);
    wr(32'h7f14, 32'd2);
    wr(32'h7f00, 32'h9);
    wr(32'h7f10, 32'h9);
    step(2);
    chk("dual_pre_irq", 32'(irq), 32'd0);
    step(1);
    chk("dual_irq", 32'(irq), 32'h3);
    chk("dual_irq_any", 32'(irq_any), 32'd1);
    wr(32'h7f00, 32'h0);
    chk("dual_clr_ch0", 32'(irq), 32'h2);
    wr(32'h7f10, 32'h0);
    chk("dual_clr_ch1", 32'(irq), 32'h0);

    // CTRL write lands on the same edge ch0 would enter INT.
    wr(32'h7f04, 32'd2);
    wr(32'h7f00, 32'h9);
    step(2);
    rd(32'h7f08, d); chk("race_count_pre", d, 32'd1);
    wr(32'h7f00, 32'h8);
    chk("race_irq", 32'(irq), 32'd0);
    rd(32'h7f08, d); chk("race_count_hold", d, 32'd1);
    rd(32'h7f00, d); chk("race_ctrl", d, 32'h8);
    step(1);
    chk("race_irq_later", 32'(irq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
